// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx byte transmitter among NREQ requesters (tx_clk domain).
// Optional BUSY watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GAP  = 0
) (
  input  logic              tx_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_data,
  output logic [NREQ-1:0]   o_ack,
  output logic [2:0]        o_gnt_id,
  output logic              o_busy,
  output logic              o_uart_en,
  output logic              o_txen,
  output logic [7:0]        o_txdata,
  input  logic              i_done,
  output logic              o_err
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, BUSY, GAP_WAIT} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] ack_n;
  logic [2:0]      gnt_n;
  logic            txen_n;
  logic [7:0]      txdata_n;
  logic [3:0]      gap_cnt, gap_n;

  logic [7:0]      req8;
  logic [7:0]      data8 [8];
  logic            found;
  logic [2:0]      pick;
  logic [3:0]      idx;
  logic [7:0]      onehot;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [4:0] WDOG_LAST = 5'd19;
  logic [4:0] wdog, wdog_n;
  logic       err_n;
`endif

  assign o_uart_en = i_en;
  assign o_busy    = (state != IDLE);

  // Requests and bytes are widened to 8 lanes so the rotating search indexes cleanly for any NREQ.
  always_comb begin
    req8 = '0;
    req8[NREQ-1:0] = i_req;
    for (int unsigned n = 0; n < 8; n++) data8[n] = '0;
    for (int unsigned n = 0; n < NREQ; n++) data8[n] = i_data[8*n +: 8];
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = {1'b0, o_gnt_id} + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && req8[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
    onehot = 8'd1 << pick;
  end

  always_comb begin
    state_n  = state;
    ack_n    = '0;
    txen_n   = 1'b0;
    txdata_n = o_txdata;
    gnt_n    = o_gnt_id;
    gap_n    = gap_cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wdog_n   = wdog;
    err_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (i_en && found) begin
          txdata_n = data8[pick];
          txen_n   = 1'b1;
          ack_n    = onehot[NREQ-1:0];
          gnt_n    = pick;
          state_n  = LOAD;
        end
      end
      LOAD: state_n = ARM;
      ARM: begin
        // i_done still reflects the previous frame here, so it is not looked at.
        state_n = BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
        wdog_n  = '0;
`endif
      end
      BUSY: begin
        if (i_en) begin
          if (i_done) begin
            if (GAP > 0) begin
              gap_n   = 4'(GAP);
              state_n = GAP_WAIT;
            end else begin
              state_n = IDLE;
            end
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (wdog == WDOG_LAST) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            wdog_n = wdog + 5'd1;
          end
`endif
        end
      end
      GAP_WAIT: begin
        if (i_en) begin
          if (gap_cnt <= 4'd1) begin
            gap_n   = '0;
            state_n = IDLE;
          end else begin
            gap_n = gap_cnt - 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      o_ack    <= '0;
      o_gnt_id <= 3'(NREQ - 1);
      o_txen   <= 1'b0;
      o_txdata <= '0;
      gap_cnt  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wdog     <= '0;
      o_err    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      o_ack    <= ack_n;
      o_gnt_id <= gnt_n;
      o_txen   <= txen_n;
      o_txdata <= txdata_n;
      gap_cnt  <= gap_n;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wdog     <= wdog_n;
      o_err    <= err_n;
`endif
    end
  end

`ifndef UART_TX_ARB_TIMEOUT_EN
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: two instances (GAP=0 and GAP=3), each driving a behavioural uart_tx model.
// Grants are checked against an expected-ack scoreboard filled as requests are driven.
module tb_uart_tx_arb;
  localparam int unsigned NREQ = 4;

  logic tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  logic                rstn;
  logic                kill;
  logic [NREQ-1:0]     req    [2];
  logic [8*NREQ-1:0]   data   [2];
  logic                en     [2];
  logic [NREQ-1:0]     ack    [2];
  logic [2:0]          gnt    [2];
  logic                busy   [2];
  logic                uen    [2];
  logic                txen   [2];
  logic [7:0]          txdata [2];
  logic                err    [2];
  logic                done_m [2];
  logic                txen_q [2];
  logic [3:0]          cnt    [2];
  logic [9:0]          sh     [2];
  logic                done0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int id; logic [7:0] b;} exp_t;
  exp_t sb[$];

  assign done0 = done_m[0] & ~kill;

  uart_tx_arb #(.NREQ(NREQ), .GAP(0)) dut (
    .tx_clk(tx_clk), .i_rstn(rstn), .i_en(en[0]), .i_req(req[0]), .i_data(data[0]),
    .o_ack(ack[0]), .o_gnt_id(gnt[0]), .o_busy(busy[0]), .o_uart_en(uen[0]),
    .o_txen(txen[0]), .o_txdata(txdata[0]), .i_done(done0), .o_err(err[0]));

  uart_tx_arb #(.NREQ(NREQ), .GAP(3)) dut_gap (
    .tx_clk(tx_clk), .i_rstn(rstn), .i_en(en[1]), .i_req(req[1]), .i_data(data[1]),
    .o_ack(ack[1]), .o_gnt_id(gnt[1]), .o_busy(busy[1]), .o_uart_en(uen[1]),
    .o_txen(txen[1]), .o_txdata(txdata[1]), .i_done(done_m[1]), .o_err(err[1]));

  always @(posedge tx_clk) cyc <= cyc + 1;

  // Transmitter model: loads on a rising i_txen, shifts 10 bits, done stays stale-high one cycle after load.
  always @(posedge tx_clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] <= '0; sh[k] <= '1; done_m[k] <= 1'b1; txen_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        txen_q[k] <= txen[k];
        if (uen[k]) begin
          if (txen[k] && !txen_q[k]) begin
            cnt[k] <= 4'd10;
            sh[k]  <= {1'b1, txdata[k], 1'b0};
          end else if (cnt[k] != 0) begin
            cnt[k]    <= cnt[k] - 4'd1;
            done_m[k] <= (cnt[k] == 4'd1);
            sh[k]     <= {1'b1, sh[k][9:1]};
          end
        end
      end
    end
  end

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(negedge tx_clk);
    rstn = 1'b1;
  endtask

  task automatic wait_ack(input int k, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge tx_clk);
      if (|ack[k]) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int k, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge tx_clk);
      if (!busy[k]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    checks++;
    if (ack[0] !== 4'b0000 || txen[0] !== 1'b0 || txdata[0] !== 8'h00 || gnt[0] !== 3'd3 ||
        busy[0] !== 1'b0 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ack=%b txen=%b txdata=%h gnt=%0d busy=%b err=%b expected 0000 0 00 3 0 0",
               ack[0], txen[0], txdata[0], gnt[0], busy[0], err[0]);
    end
    @(negedge tx_clk);
    @(negedge tx_clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    bit got;
    int g;
    exp_t e;
    logic [9:0] fr;
    en[0] = 1'b1; req[0] = 4'b0100; data[0] = 32'h00A5_0000;
    sb.push_back('{2, 8'hA5});
    wait_ack(0, 10, got);
    g = cyc;
    req[0] = '0;
    checks++;
    if (!got) begin errors++; $display("FAIL single_ack_timeout: got none expected ack"); end
    e = sb.pop_front();
    checks++;
    if (ack[0] !== (4'b1 << e.id) || gnt[0] !== 3'(e.id) || txdata[0] !== e.b || txen[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: ack=%b gnt=%0d txdata=%h txen=%b expected %b %0d %h 1",
               ack[0], gnt[0], txdata[0], txen[0], 4'b1 << e.id, e.id, e.b);
    end
    @(negedge tx_clk);
    checks++;
    if (ack[0] !== 4'b0000 || txen[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: ack=%b txen=%b expected 0000 0", ack[0], txen[0]);
    end
    fr = {1'b1, e.b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge tx_clk);
      checks++;
      if (sh[0][0] !== fr[i]) begin
        errors++;
        $display("FAIL single_line_bit%0d: got %b expected %b", i, sh[0][0], fr[i]);
      end
    end
    wait_idle(0, 20, got);
    checks++;
    if (!got || cyc - g != 12) begin
      errors++;
      $display("FAIL single_busy_len: got %0d cycles expected 12", cyc - g);
    end
  endtask

  task automatic test_round_robin();
    bit got;
    int prev;
    int ids [6];
    exp_t e;
    ids = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    en[0] = 1'b1; data[0] = 32'h1312_1110; req[0] = 4'b1111;
    for (int j = 0; j < 6; j++) sb.push_back('{ids[j], 8'h10 + 8'(ids[j])});
    prev = 0;
    for (int j = 0; j < 6; j++) begin
      wait_ack(0, 20, got);
      checks++;
      if (!got) begin errors++; $display("FAIL rr_ack_timeout: grant %0d missing", j); end
      e = sb.pop_front();
      checks++;
      if (ack[0] !== (4'b1 << e.id) || gnt[0] !== 3'(e.id) || txdata[0] !== e.b) begin
        errors++;
        $display("FAIL rr_grant%0d: ack=%b gnt=%0d txdata=%h expected %b %0d %h",
                 j, ack[0], gnt[0], txdata[0], 4'b1 << e.id, e.id, e.b);
      end
      if (j > 0) begin
        checks++;
        if (cyc - prev != 13) begin
          errors++;
          $display("FAIL rr_spacing%0d: got %0d expected 13", j, cyc - prev);
        end
      end
      prev = cyc;
      @(negedge tx_clk);
      checks++;
      if (ack[0] !== 4'b0000) begin
        errors++;
        $display("FAIL rr_ack_width%0d: got %b expected 0000", j, ack[0]);
      end
    end
    req[0] = '0;
    wait_idle(0, 30, got);
  endtask

  task automatic test_gap();
    bit got;
    int g;
    exp_t e;
    apply_reset();
    en[1] = 1'b1; data[1] = 32'h0000_B2B1; req[1] = 4'b0011;
    sb.push_back('{0, 8'hB1}); sb.push_back('{1, 8'hB2}); sb.push_back('{0, 8'hB1});
    wait_ack(1, 10, got);
    g = cyc;
    for (int j = 0; j < 3; j++) begin
      e = sb.pop_front();
      checks++;
      if (ack[1] !== (4'b1 << e.id) || txdata[1] !== e.b) begin
        errors++;
        $display("FAIL gap_grant%0d: ack=%b txdata=%h expected %b %h", j, ack[1], txdata[1], 4'b1 << e.id, e.b);
      end
      if (j == 2) break;
      while (cyc < g + 11) @(negedge tx_clk);
      for (int i = 0; i < 4; i++) begin
        @(negedge tx_clk);
        checks++;
        if (sh[1][0] !== 1'b1 || ack[1] !== 4'b0000) begin
          errors++;
          $display("FAIL gap_idle_line: line=%b ack=%b expected 1 0000", sh[1][0], ack[1]);
        end
      end
      wait_ack(1, 20, got);
      checks++;
      if (!got || cyc - g != 16) begin
        errors++;
        $display("FAIL gap_spacing%0d: got %0d expected 16", j, cyc - g);
      end
      g = cyc;
    end
    req[1] = '0;
    wait_idle(1, 40, got);
    checks++;
    if (!got) begin errors++; $display("FAIL gap_idle_timeout: busy=%b expected 0", busy[1]); end
  endtask

  task automatic test_enable();
    bit got;
    int g;
    exp_t e;
    apply_reset();
    en[0] = 1'b0; req[0] = 4'b0001; data[0] = 32'h0000_005A;
    repeat (5) begin
      @(negedge tx_clk);
      checks++;
      if (ack[0] !== 4'b0000 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL en_low_no_grant: ack=%b busy=%b expected 0000 0", ack[0], busy[0]);
      end
    end
    en[0] = 1'b1;
    sb.push_back('{0, 8'h5A});
    wait_ack(0, 10, got);
    g = cyc;
    req[0] = '0;
    e = sb.pop_front();
    checks++;
    if (!got || ack[0] !== (4'b1 << e.id) || txdata[0] !== e.b) begin
      errors++;
      $display("FAIL en_grant: ack=%b txdata=%h expected %b %h", ack[0], txdata[0], 4'b1 << e.id, e.b);
    end
    repeat (4) @(negedge tx_clk);
    en[0] = 1'b0;
    repeat (5) @(negedge tx_clk);
    en[0] = 1'b1;
    wait_idle(0, 30, got);
    checks++;
    if (!got || cyc - g != 17) begin
      errors++;
      $display("FAIL en_freeze_len: got %0d cycles expected 17", cyc - g);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    exp_t e;
    apply_reset();
    en[0] = 1'b1; req[0] = 4'b0010; data[0] = 32'h0000_C300;
    sb.push_back('{1, 8'hC3});
    wait_ack(0, 10, got);
    req[0] = '0;
    e = sb.pop_front();
    checks++;
    if (!got || gnt[0] !== 3'(e.id) || txdata[0] !== e.b) begin
      errors++;
      $display("FAIL rst_first_grant: gnt=%0d txdata=%h expected %0d %h", gnt[0], txdata[0], e.id, e.b);
    end
    repeat (5) @(negedge tx_clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (txen[0] !== 1'b0 || ack[0] !== 4'b0000 || busy[0] !== 1'b0 || gnt[0] !== 3'd3) begin
      errors++;
      $display("FAIL rst_async: txen=%b ack=%b busy=%b gnt=%0d expected 0 0000 0 3",
               txen[0], ack[0], busy[0], gnt[0]);
    end
    repeat (2) @(negedge tx_clk);
    req[0] = 4'b0011; data[0] = 32'h0000_D2D1;
    rstn = 1'b1;
    sb.push_back('{0, 8'hD1});
    wait_ack(0, 10, got);
    req[0] = '0;
    e = sb.pop_front();
    checks++;
    if (!got || ack[0] !== (4'b1 << e.id) || txdata[0] !== e.b) begin
      errors++;
      $display("FAIL rst_regrant: ack=%b txdata=%h expected %b %h", ack[0], txdata[0], 4'b1 << e.id, e.b);
    end
    wait_idle(0, 30, got);
  endtask

  task automatic test_timeout();
    bit got;
    int g;
    exp_t e;
    apply_reset();
    en[0] = 1'b1; req[0] = 4'b0011; data[0] = 32'h0000_E2E1;
    sb.push_back('{0, 8'hE1});
    wait_ack(0, 10, got);
    g = cyc;
    req[0] = 4'b0010;
    e = sb.pop_front();
    checks++;
    if (!got || ack[0] !== (4'b1 << e.id)) begin
      errors++;
      $display("FAIL to_first_grant: ack=%b expected %b", ack[0], 4'b1 << e.id);
    end
    repeat (2) @(negedge tx_clk);
    kill = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    sb.push_back('{1, 8'hE2});
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge tx_clk);
      if (err[0]) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || cyc - g != 22 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL to_err_pulse: at %0d busy=%b expected 22 0", cyc - g, busy[0]);
    end
    wait_ack(0, 10, got);
    e = sb.pop_front();
    checks++;
    if (!got || cyc - g != 23 || ack[0] !== (4'b1 << e.id) || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL to_next_grant: at %0d ack=%b err=%b expected 23 %b 0", cyc - g, ack[0], err[0], 4'b1 << e.id);
    end
    req[0] = '0;
    kill = 1'b0;
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge tx_clk);
      checks++;
      if (err[0] !== 1'b0) begin errors++; $display("FAIL to_no_err: got %b expected 0", err[0]); end
    end
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL to_stuck_busy: got %b expected 1", busy[0]); end
    req[0] = '0;
    kill = 1'b0;
`endif
    wait_idle(0, 30, got);
    checks++;
    if (!got) begin errors++; $display("FAIL to_recover: busy=%b expected 0", busy[0]); end
  endtask

  initial begin
    rstn = 1'b0; kill = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; data[k] = '0; en[k] = 1'b0;
    end
    @(negedge tx_clk);
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_enable();
    test_reset_mid_frame();
    test_timeout();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete expected $finish");
    $fatal(1, "timeout");
  end

endmodule
